// File: rtl/irq_dispatch_unit.sv
// irq_dispatch_unit: takes a pending interrupt at an instruction boundary,
// acknowledges it, clears SREG.I, pushes the return PC (low byte first) and
// jumps to the vector, holding the CPU pipeline stalled throughout.
module irq_dispatch_unit #(
  parameter int DATA_WIDTH   = 8,
  parameter int I_ADDR_WIDTH = 10,
  parameter int D_ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    irq,
  input  logic [I_ADDR_WIDTH-1:0] vector,
  input  logic                    instr_boundary,
  input  logic [I_ADDR_WIDTH-1:0] pc,
  input  logic [D_ADDR_WIDTH-1:0] sp,
  output logic                    ack,
  output logic                    stall,
  output logic                    sreg_clr_i,
  output logic                    mem_we,
  output logic [D_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    sp_dec,
  output logic                    pc_load,
  output logic [I_ADDR_WIDTH-1:0] pc_target
);

  typedef enum logic [2:0] {IDLE, ACK, PUSH_LO, PUSH_HI, JUMP} state_t;

  localparam logic [D_ADDR_WIDTH-1:0] SP_ONE = D_ADDR_WIDTH'(1);

  state_t                  state_q;
  logic [I_ADDR_WIDTH-1:0] vec_q;
  logic [I_ADDR_WIDTH-1:0] pc_q;
  logic [D_ADDR_WIDTH-1:0] sp_q;
  logic                    ack_q, stall_q, sclr_q, we_q, spdec_q, pcl_q;
  logic [D_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  // Return PC zero-extended to two stack bytes so the high byte is well defined
  logic [2*DATA_WIDTH-1:0] pc_ext_d;

  // Widen the latched return PC to two full stack bytes
  always_comb begin
    pc_ext_d = '0;
    pc_ext_d[I_ADDR_WIDTH-1:0] = pc_q;
  end

  // Dispatch sequencer; outputs are registered alongside the state so every
  // output is a flop and reset clears them all at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pc_q    <= '0;
      sp_q    <= '0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      sclr_q  <= 1'b0;
      we_q    <= 1'b0;
      spdec_q <= 1'b0;
      pcl_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      sclr_q  <= 1'b0;
      we_q    <= 1'b0;
      spdec_q <= 1'b0;
      pcl_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      case (state_q)
        IDLE: begin
          // Vector 0 is the reset vector and is never dispatched
          if (irq && instr_boundary && (vector != '0)) begin
            vec_q   <= vector;
            pc_q    <= pc;
            sp_q    <= sp;
            state_q <= ACK;
            ack_q   <= 1'b1;
            sclr_q  <= 1'b1;
            stall_q <= 1'b1;
          end
        end
        ACK: begin
          state_q <= PUSH_LO;
          we_q    <= 1'b1;
          addr_q  <= sp_q;
          wdata_q <= pc_ext_d[DATA_WIDTH-1:0];
          spdec_q <= 1'b1;
          stall_q <= 1'b1;
        end
        PUSH_LO: begin
          state_q <= PUSH_HI;
          we_q    <= 1'b1;
          addr_q  <= sp_q - SP_ONE;
          wdata_q <= pc_ext_d[2*DATA_WIDTH-1:DATA_WIDTH];
          spdec_q <= 1'b1;
          stall_q <= 1'b1;
        end
        PUSH_HI: begin
          state_q <= JUMP;
          pcl_q   <= 1'b1;
          stall_q <= 1'b1;
        end
        JUMP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign stall      = stall_q;
  assign sreg_clr_i = sclr_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign sp_dec     = spdec_q;
  assign pc_load    = pcl_q;
  assign pc_target  = vec_q;

endmodule
